// File: rtl/int_controller_pkg.sv
// common: shared state encoding and constants for the interrupt controller
package common;
    typedef enum logic [1:0] {IDLE, ACK, DONE} state_t;
    localparam logic [2:0] SPURIOUS_IDX = 3'd7;
endpackage

// File: rtl/int_controller_prio_enc.sv
// int_prio_enc: fixed-priority encoder, bit 0 highest, bit 3 lowest
module int_prio_enc (
    input  logic [3:0] active,
    output logic [2:0] idx,
    output logic       valid
);
    // lowest set bit wins; idx is meaningless when valid is low
    always_comb begin
        idx   = active[0] ? 3'd0 : active[1] ? 3'd1 : active[2] ? 3'd2 : 3'd3;
        valid = |active;
    end
endmodule

// File: rtl/int_controller.sv
// int_controller: four-source vectored interrupt controller with I/O-mapped registers
module int_controller
    import common::*;
#(
    parameter logic [7:0] PORT_EN   = 8'h1F,
    parameter logic [7:0] PORT_VEC  = 8'h3F,
    parameter logic [7:0] PORT_STAT = 8'h5F,
    parameter logic [5:0] FRAME_LEN = 6'd32
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       clkcpu_ck,
    input  logic [3:0] src_req,
    input  logic       bus_m1,
    input  logic       bus_iorq,
    input  logic       bus_rd,
    input  logic       bus_wr,
    input  logic [7:0] bus_a,
    input  logic [7:0] bus_d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       n_int
);
    state_t     state, state_nxt;
    logic [3:0] pending, pending_nxt, enable, base, clr;
    logic [2:0] idx, enc_idx;
    logic [5:0] cnt;
    logic       enc_valid, intack_q, io_wr, io_rd, inta_rise, expire, n_int_q;

    int_prio_enc u_prio (
        .active(pending & enable),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign io_wr     = bus_iorq & bus_wr & ~bus_m1;
    assign io_rd     = bus_iorq & bus_rd & ~bus_m1;
    assign inta_rise = bus_m1 & bus_iorq & ~intack_q;
    assign expire    = clkcpu_ck & pending[0] & (state != ACK) & (cnt == FRAME_LEN - 6'd1);
    assign n_int     = n_int_q;

    // pending clears from acknowledge, status write-1-to-clear and frame expiry; new requests win
    always_comb begin
        clr = (io_wr && bus_a == PORT_STAT) ? bus_d_in[3:0] : 4'b0000;
        clr = clr | ((state == DONE && idx != SPURIOUS_IDX) ? (4'b0001 << idx[1:0]) : 4'b0000);
        clr = clr | {3'b000, expire};
        pending_nxt = (pending & ~clr) | src_req;
        state_nxt = (state == IDLE) ? (inta_rise ? ACK : IDLE) :
                    (state == ACK)  ? (bus_iorq ? ACK : DONE) : IDLE;
    end

    // data bus: vector during acknowledge, otherwise register reads; silent under reset
    always_comb begin
        d_oe  = 1'b0;
        d_out = 8'h00;
        if (!rst) begin
            if (state == ACK) begin
                d_oe  = 1'b1;
                d_out = {base, idx, 1'b0};
            end else if (io_rd && bus_a == PORT_EN) begin
                d_oe  = 1'b1;
                d_out = {4'h0, enable};
            end else if (io_rd && bus_a == PORT_VEC) begin
                d_oe  = 1'b1;
                d_out = {base, 4'h0};
            end else if (io_rd && bus_a == PORT_STAT) begin
                d_oe  = 1'b1;
                d_out = {4'h0, pending};
            end
        end
    end

    // control state, registers, latched vector index and CPU-clocked interrupt line
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= 4'b0000;
            enable   <= 4'b0001;
            base     <= 4'hF;
            idx      <= SPURIOUS_IDX;
            intack_q <= 1'b0;
            n_int_q  <= 1'b1;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            intack_q <= bus_m1 & bus_iorq;
            if (io_wr && bus_a == PORT_EN) enable <= bus_d_in[3:0];
            if (io_wr && bus_a == PORT_VEC) base <= bus_d_in[7:4];
            if (state == IDLE && inta_rise) idx <= enc_valid ? enc_idx : SPURIOUS_IDX;
            if (clkcpu_ck) n_int_q <= ~((|(pending_nxt & enable)) && state == IDLE);
        end
    end

    // source-0 expiry: counts CPU clocks while pending, restarts on each new request, frozen in ACK
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) cnt <= 6'd0;
        else if (src_req[0] || !pending[0] || expire) cnt <= 6'd0;
        else if (clkcpu_ck && state != ACK) cnt <= cnt + 6'd1;
    end
endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: directed stimulus with a queue-based scoreboard for int_controller
module tb_int_controller;
  localparam logic [7:0] P_EN = 8'h1F, P_VEC = 8'h3F, P_STAT = 8'h5F;
  logic       clk28 = 1'b0, rst = 1'b1, clkcpu_ck = 1'b0;
  logic [3:0] src_req = 4'h0;
  logic       bus_m1 = 1'b0, bus_iorq = 1'b0, bus_rd = 1'b0, bus_wr = 1'b0;
  logic [7:0] bus_a = 8'h00, bus_d_in = 8'h00;
  logic [7:0] d_out;
  logic       d_oe, n_int;
  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } exp_t;
  exp_t q[$];
  event chk_ev;
  int   passes = 0, total = 0;
  int_controller dut (
    .clk28(clk28), .rst(rst), .clkcpu_ck(clkcpu_ck), .src_req(src_req),
    .bus_m1(bus_m1), .bus_iorq(bus_iorq), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_a(bus_a), .bus_d_in(bus_d_in), .d_out(d_out), .d_oe(d_oe), .n_int(n_int)
  );
  always #5 clk28 = ~clk28;
  initial forever begin
    @(chk_ev);
    while (q.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e   = q.pop_front();
      act = (e.sel == 0) ? d_out : (e.sel == 1) ? {7'b0, d_oe} : {7'b0, n_int};
      total++;
      if (act === e.exp) passes++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  end
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk28);
    #1;
  endtask
  task automatic expect_out(input string name, input int sel, input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    q.push_back(e);
    #1;
    -> chk_ev;
    #1;
  endtask
  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      clkcpu_ck = 1'b1;
      tick();
      clkcpu_ck = 1'b0;
    end
  endtask
  task automatic pulse(input logic [3:0] r);
    src_req = r;
    tick();
    src_req = 4'h0;
  endtask
  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    bus_iorq = 1'b1; bus_wr = 1'b1; bus_a = a; bus_d_in = d;
    tick();
    bus_iorq = 1'b0; bus_wr = 1'b0;
  endtask
  task automatic io_read(input string name, input logic [7:0] a, input logic [7:0] exp);
    bus_iorq = 1'b1; bus_rd = 1'b1; bus_a = a;
    expect_out({name, "_oe"}, 1, 8'h01);
    expect_out(name, 0, exp);
    bus_iorq = 1'b0; bus_rd = 1'b0;
    tick();
  endtask
  task automatic inta_start();
    bus_m1 = 1'b1; bus_iorq = 1'b1;
    tick();
  endtask
  task automatic inta_end();
    bus_m1 = 1'b0; bus_iorq = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    tick();
    expect_out("rst_n_int", 2, 8'h01);
    expect_out("rst_d_oe", 1, 8'h00);
    expect_out("rst_d_out", 0, 8'h00);
    check("rst_state_idle", {6'b0, dut.state}, 8'h00);
    check("rst_pending", {4'b0, dut.pending}, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    io_read("rst_vec", P_VEC, 8'hF0);
    io_read("rst_en", P_EN, 8'h01);
    io_read("rst_stat", P_STAT, 8'h00);
    expect_out("idle_d_oe", 1, 8'h00);
    pulse(4'b0001);
    strobe(1);
    expect_out("frame_n_int_low", 2, 8'h00);
    io_read("frame_pending", P_STAT, 8'h01);
    strobe(30);
    expect_out("frame_n_int_31", 2, 8'h00);
    strobe(1);
    expect_out("frame_n_int_expired", 2, 8'h01);
    check("frame_expired_pending", {4'b0, dut.pending}, 8'h00);
    io_read("frame_pending_expired", P_STAT, 8'h00);
    io_write(P_EN, 8'h0F);
    io_write(P_VEC, 8'hA0);
    pulse(4'b0110);
    strobe(1);
    expect_out("inta_n_int_low", 2, 8'h00);
    inta_start();
    expect_out("inta_d_oe", 1, 8'h01);
    expect_out("inta_vector", 0, 8'hA2);
    inta_end();
    io_read("inta_pending_after", P_STAT, 8'h04);
    strobe(1);
    expect_out("inta_n_int_stays", 2, 8'h00);
    io_write(P_EN, 8'h01);
    inta_start();
    expect_out("spur_vector", 0, 8'hAE);
    inta_end();
    io_read("spur_pending", P_STAT, 8'h04);
    pulse(4'b0010);
    io_read("pre_clear_pending", P_STAT, 8'h06);
    src_req = 4'b0100;
    io_write(P_STAT, 8'h0F);
    src_req = 4'h0;
    io_read("set_wins", P_STAT, 8'h04);
    io_write(P_EN, 8'h0F);
    inta_start();
    expect_out("hold_vector", 0, 8'hA4);
    pulse(4'b0001);
    expect_out("hold_vector_after_req", 0, 8'hA4);
    inta_end();
    io_read("hold_pending", P_STAT, 8'h01);
    io_write(P_EN, 8'h05);
    io_read("en_readback", P_EN, 8'h05);
    strobe(1);
    expect_out("mid_n_int_low", 2, 8'h00);
    inta_start();
    expect_out("mid_vector", 0, 8'hA0);
    rst = 1'b1; bus_m1 = 1'b0; bus_iorq = 1'b0;
    expect_out("mid_rst_d_oe", 1, 8'h00);
    expect_out("mid_rst_d_out", 0, 8'h00);
    expect_out("mid_rst_n_int", 2, 8'h01);
    tick();
    rst = 1'b0;
    tick();
    expect_out("post_rst_idle", 1, 8'h00);
    io_read("post_rst_vec", P_VEC, 8'hF0);
    io_read("post_rst_stat", P_STAT, 8'h00);
    #2;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
